// File: rtl/digit_scan_driver.sv
// rtl/digit_scan_driver.sv - eight-digit 7-segment scan driver with frame-synchronous reload
//
// Purpose:
//   Holds a shadow copy of eight hex digits and their decimal-point mask.
//   Each digit is decoded to 7-segment code and driven onto a shared segment
//   bus, one digit at a time. Every digit is shown for DIV cycles, and then
//   all digits are off for GAP cycles so the previous digit does not ghost
//   into the next one. Loads that arrive during a scan go into a pending
//   buffer. That buffer is moved into the shadow copy only at the wrap back
//   to digit 0, so a frame never mixes old and new digits.
//
// Ports:
//   CLK    in   1  system clock, rising edge
//   RST    in   1  synchronous reset, active-low
//   Load   in   1  capture D0in..D7in / DPin this cycle
//   D0in..D7in in 4 hex digits, D0 least significant
//   DPin   in   8  decimal-point mask, bit i = digit i
//   LZB    in   1  leading-zero blanking enable
//   SEG    out  8  segments a..g,dp (active-high)
//   COM    out  8  digit enables (active-low, one-cold)
//   Frame  out  1  one-cycle pulse when digit 0 starts being shown

module digit_scan_driver #(
    parameter int DIV = 1000,
    parameter int GAP = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Load,
    input  logic [3:0] D0in,
    input  logic [3:0] D1in,
    input  logic [3:0] D2in,
    input  logic [3:0] D3in,
    input  logic [3:0] D4in,
    input  logic [3:0] D5in,
    input  logic [3:0] D6in,
    input  logic [3:0] D7in,
    input  logic [7:0] DPin,
    input  logic       LZB,
    output logic [7:0] SEG,
    output logic [7:0] COM,
    output logic       Frame
);

    localparam int MAXC = (DIV > GAP) ? DIV : GAP;
    localparam int PW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [PW-1:0] DIV_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] GAP_LAST = PW'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [2:0]      idx_q, idx_d;
    logic [31:0]     shadow_q, shadow_d;
    logic [7:0]      shdp_q, shdp_d;
    logic [31:0]     pend_q, pend_d;
    logic [7:0]      pdp_q, pdp_d;
    logic            pvalid_q, pvalid_d;
    logic [7:0]      seg_q, seg_d;
    logic [7:0]      com_q, com_d;
    logic            frame_q, frame_d;

    logic [31:0]     din_all;
    logic [7:0]      lead_zero;
    logic [3:0]      cur_digit;
    logic            blank;

    assign din_all = {D7in, D6in, D5in, D4in, D3in, D2in, D1in, D0in};

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Scan sequencing, the pending/shadow buffers and the frame pulse.
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        shdp_d   = shdp_q;
        pend_d   = pend_q;
        pdp_d    = pdp_q;
        pvalid_d = pvalid_q;
        frame_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Nothing is on screen yet, so the first load can go straight to the shadow copy.
                if (Load) begin
                    shadow_d = din_all;
                    shdp_d   = DPin;
                    state_d  = ST_SHOW;
                    idx_d    = 3'd0;
                    presc_d  = '0;
                    frame_d  = 1'b1;
                end
            end
            ST_SHOW: begin
                if (presc_q == DIV_LAST) begin
                    state_d = ST_GAP;
                    presc_d = '0;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (presc_q == GAP_LAST) begin
                    state_d = ST_SHOW;
                    presc_d = '0;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        frame_d = 1'b1;
                        if (pvalid_q) begin
                            shadow_d = pend_q;
                            shdp_d   = pdp_q;
                            pvalid_d = 1'b0;
                        end
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // This comes after the wrap transfer. A load on the wrap edge therefore
        // refills pending (the old pending was already moved) and stays valid for the next frame.
        if (state_q != ST_IDLE && Load) begin
            pend_d   = din_all;
            pdp_d    = DPin;
            pvalid_d = 1'b1;
        end
    end

    // Leading-zero chain: lead_zero[k] is set when shadow digits 7..k are all zero.
    always_comb begin
        lead_zero    = 8'h00;
        lead_zero[7] = (shadow_d[31:28] == 4'h0);
        for (int k = 6; k >= 0; k--) begin
            lead_zero[k] = lead_zero[k+1] & (shadow_d[k*4 +: 4] == 4'h0);
        end
    end

    // Outputs are computed from the next state, so the registered bus lines up with the state.
    always_comb begin
        cur_digit = shadow_d[idx_d*4 +: 4];
        blank     = LZB && (idx_d != 3'd0) && lead_zero[idx_d];
        com_d     = 8'hFF;
        seg_d     = 8'h00;
        if (state_d == ST_SHOW) begin
            com_d = ~(8'h01 << idx_d);
            seg_d = {shdp_d[idx_d], blank ? 7'h00 : hex_to_seg(cur_digit)};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            idx_q    <= 3'd0;
            shadow_q <= 32'h0;
            shdp_q   <= 8'h00;
            pend_q   <= 32'h0;
            pdp_q    <= 8'h00;
            pvalid_q <= 1'b0;
            seg_q    <= 8'h00;
            com_q    <= 8'hFF;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            shdp_q   <= shdp_d;
            pend_q   <= pend_d;
            pdp_q    <= pdp_d;
            pvalid_q <= pvalid_d;
            seg_q    <= seg_d;
            com_q    <= com_d;
            frame_q  <= frame_d;
        end
    end

    assign SEG   = seg_q;
    assign COM   = com_q;
    assign Frame = frame_q;

endmodule

// File: tb/tb_digit_scan_driver.sv
// tb/tb_digit_scan_driver.sv - self-checking bench for digit_scan_driver

module tb_digit_scan_driver;

    localparam int DIV = 4;
    localparam int GAP = 1;
    localparam int SLOT = DIV + GAP;
    localparam int FRAME_LEN = 8 * SLOT;

    logic        CLK;
    logic        RST;
    logic        Load;
    logic [31:0] din;
    logic [7:0]  DPin;
    logic        LZB;
    logic [7:0]  SEG;
    logic [7:0]  COM;
    logic        Frame;

    int n_checks;
    int n_fail;

    digit_scan_driver #(.DIV(DIV), .GAP(GAP)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .Load  (Load),
        .D0in  (din[3:0]),
        .D1in  (din[7:4]),
        .D2in  (din[11:8]),
        .D3in  (din[15:12]),
        .D4in  (din[19:16]),
        .D5in  (din[23:20]),
        .D6in  (din[27:24]),
        .D7in  (din[31:28]),
        .DPin  (DPin),
        .LZB   (LZB),
        .SEG   (SEG),
        .COM   (COM),
        .Frame (Frame)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [31:0] d;
        logic [7:0]  dp;
        logic        lzb;
        logic [63:0] segs;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cmp(input string name, input logic [16:0] act, input logic [16:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {frame,com,seg}=%h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RST  = 1'b0;
        Load = 1'b0;
        tick();
        RST  = 1'b1;
    endtask

    // Entry: at cycle 0 of digit 0. Checks one whole frame, then the frame pulse of the next one.
    // The loads are applied during cycle l1 and cycle l2 (-1 disables a load).
    task automatic check_frame(input string name, input logic [63:0] segs,
                               input int l1, input logic [31:0] d1,
                               input int l2, input logic [31:0] d2);
        logic [16:0] e;
        int k;
        int c;
        for (int t = 0; t < FRAME_LEN; t++) begin
            k = t / SLOT;
            c = t % SLOT;
            if (c < DIV)
                e = {(t == 0), ~(8'h01 << k), segs[k*8 +: 8]};
            else
                e = {1'b0, 8'hFF, 8'h00};
            cmp(name, {Frame, COM, SEG}, e);
            if (t == l1) begin
                Load = 1'b1; din = d1; DPin = 8'h00;
            end else if (t == l2) begin
                Load = 1'b1; din = d2; DPin = 8'h00;
            end else begin
                Load = 1'b0;
            end
            tick();
        end
        Load = 1'b0;
        cmp({name, "_next_frame"}, {Frame, COM}, {1'b1, 8'hFE});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST  = 1'b0;
        Load = 1'b0;
        din  = 32'h0;
        DPin = 8'h00;
        LZB  = 1'b0;

        vecs[0] = '{32'h76543210, 8'h00, 1'b0, 64'h077D6D664F5B063F};
        vecs[1] = '{32'hFEDCBA98, 8'h00, 1'b0, 64'h71795E397C776F7F};
        vecs[2] = '{32'h00000100, 8'h00, 1'b1, 64'h0000000000063F3F};
        vecs[3] = '{32'h00000000, 8'h00, 1'b1, 64'h000000000000003F};
        vecs[4] = '{32'h00000000, 8'h80, 1'b1, 64'h800000000000003F};
        vecs[5] = '{32'h00000000, 8'hA5, 1'b0, 64'hBF3FBF3F3FBF3FBF};
        vecs[6] = '{32'h03000000, 8'h01, 1'b1, 64'h004F3F3F3F3F3FBF};

        tick();
        tick();
        cmp("reset_state", {Frame, COM, SEG}, {1'b0, 8'hFF, 8'h00});
        RST = 1'b1;

        // Idle without a load: the display must stay dark.
        for (int i = 0; i < 100; i++) begin
            tick();
            cmp("idle_hold", {Frame, COM, SEG}, {1'b0, 8'hFF, 8'h00});
        end

        // Table-driven decode / dp / blanking frames.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            din  = vecs[v].d;
            DPin = vecs[v].dp;
            LZB  = vecs[v].lzb;
            Load = 1'b1;
            tick();
            Load = 1'b0;
            check_frame($sformatf("vec%0d", v), vecs[v].segs, -1, 32'h0, -1, 32'h0);
        end

        // Load during digit 3: the current frame is unchanged and the next frame shows the new digits.
        LZB = 1'b0;
        do_reset();
        din = 32'h76543210; DPin = 8'h00; Load = 1'b1;
        tick();
        Load = 1'b0;
        check_frame("midload_old", 64'h077D6D664F5B063F, 3*SLOT + 1, 32'h88888888, -1, 32'h0);
        check_frame("midload_new", {8{8'h7F}}, 7, 32'h88888888, 22, 32'hFFFFFFFF);
        check_frame("lastload_wins", {8{8'h71}}, -1, 32'h0, -1, 32'h0);

        // Load on the GAP->digit-0 edge goes to the frame after the next one.
        check_frame("wrap_pre", {8{8'h71}}, 10, 32'h22222222, FRAME_LEN - 1, 32'h55555555);
        check_frame("wrap_old_pending", {8{8'h5B}}, -1, 32'h0, -1, 32'h0);
        check_frame("wrap_new_data", {8{8'h6D}}, -1, 32'h0, -1, 32'h0);

        // Reset in the middle of digit 5.
        for (int t = 0; t < 5*SLOT + 2; t++) tick();
        cmp("pre_reset_digit5", {Frame, COM, SEG}, {1'b0, 8'hDF, 8'h6D});
        RST = 1'b0;
        tick();
        RST = 1'b1;
        cmp("midscan_reset", {Frame, COM, SEG}, {1'b0, 8'hFF, 8'h00});
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("post_reset_idle", {Frame, COM, SEG}, {1'b0, 8'hFF, 8'h00});
        end
        din = 32'h76543210; DPin = 8'h00; Load = 1'b1;
        tick();
        Load = 1'b0;
        check_frame("restart", 64'h077D6D664F5B063F, -1, 32'h0, -1, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
